mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_pkg.sv | 39 +++
 rtl/mem_access_ctrl_if.sv | 29 ++
 rtl/mem_byte_lane.sv | 49 ++++
 rtl/mem_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage access controller: access size
// encodings, FSM state encoding and the alignment check.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Legacy state codes, kept as named constants so external decoders can
    // still refer to them; the enum below reuses the same values.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        WAIT  = ST_WAIT,
        WRITE = ST_WRITE,
        RESP  = ST_RESP,
        ERR   = ST_ERR
    } state_t;

    // True for an illegal size or an address not aligned to the access size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response channel between the MEM pipeline stage (master) and the
// memory access controller (slave).
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    import mem_access_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_byte_lane.sv
// Combinational lane steering: extracts and extends sub-word load data and,
// when MEM_SUBWORD_EN is defined, merges sub-word store data into a read word.
module mem_byte_lane
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
`ifdef MEM_SUBWORD_EN
    ,
    input  logic [31:0] wdata,
    output logic [31:0] store_data
`endif
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed lane and zero/sign-extend it to a full word.
    always_comb begin
        case (lane)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: load_data = {{24{is_signed & byte_v[7]}}, byte_v};
            SZ_HALF: load_data = {{16{is_signed & half_v[15]}}, half_v};
            default: load_data = rdata;
        endcase
    end

`ifdef MEM_SUBWORD_EN
    // Overwrite only the addressed byte/half of the read word.
    always_comb begin
        store_data = rdata;
        case (size)
            SZ_BYTE: store_data[{lane, 3'b000} +: 8]        = wdata[7:0];
            SZ_HALF: store_data[{lane[1], 4'b0000} +: 16]   = wdata[15:0];
            default: store_data = wdata;
        endcase
    end
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller. Sequences loads, word stores and
// (with MEM_SUBWORD_EN defined) read-modify-write sub-word stores against a
// word-addressed memory with one-cycle read latency.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic               clk,
    input  logic               reset,
    mem_access_ctrl_if.slave   bus,
    output logic [31:0]        address,
    output logic [31:0]        write_data,
    output logic               memwrite,
    output logic               memread,
    input  logic [31:0]        read_data
);

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        access_err;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        signed_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] load_word;
`ifdef MEM_SUBWORD_EN
    logic        write_q;
    logic [31:0] store_word;
`endif

    // Request acceptance and the error classification of the incoming request.
    always_comb begin
        accept = (state == IDLE) && bus.req_valid;
`ifdef MEM_SUBWORD_EN
        access_err = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
        access_err = is_misaligned(bus.req_size, bus.req_addr[1:0]) ||
                     (bus.req_size != SZ_WORD);
`endif
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (access_err)
                        state_next = ERR;
                    else if (bus.req_write && bus.req_size == SZ_WORD)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ: state_next = WAIT;
            WAIT: begin
`ifdef MEM_SUBWORD_EN
                state_next = write_q ? WRITE : RESP;
`else
                state_next = RESP;
`endif
            end
            WRITE:    state_next = RESP;
            RESP:     state_next = IDLE;
            ERR:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Request latch at accept; WAIT captures load data or the merged store word.
    // write_data doubles as the store-data latch: it holds req_wdata until the
    // merge replaces it for sub-word stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            size_q      <= '0;
            lane_q      <= '0;
            signed_q    <= 1'b0;
            rsp_rdata_q <= '0;
            write_data  <= '0;
            address     <= '0;
`ifdef MEM_SUBWORD_EN
            write_q     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                size_q      <= bus.req_size;
                lane_q      <= bus.req_addr[1:0];
                signed_q    <= bus.req_signed;
                rsp_rdata_q <= '0;
                write_data  <= bus.req_wdata;
                address     <= 32'(bus.req_addr[ADDR_W-1:2]);
`ifdef MEM_SUBWORD_EN
                write_q     <= bus.req_write;
`endif
            end
            if (state == WAIT) begin
`ifdef MEM_SUBWORD_EN
                if (write_q)
                    write_data  <= store_word;
                else
                    rsp_rdata_q <= load_word;
`else
                rsp_rdata_q <= load_word;
`endif
            end
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP) || (state == ERR);
        bus.rsp_err   = (state == ERR);
        bus.rsp_rdata = rsp_rdata_q;
        memread       = (state == READ);
        memwrite      = (state == WRITE);
    end

    mem_byte_lane u_lane (
        .size       (size_q),
        .is_signed  (signed_q),
        .lane       (lane_q),
        .rdata      (read_data),
        .load_data  (load_word)
`ifdef MEM_SUBWORD_EN
        ,
        .wdata      (write_data),
        .store_data (store_word)
`endif
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl; expectations adapt to whether
// MEM_SUBWORD_EN is defined.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        memwrite;
    logic        memread;
    logic        mem_load;

    logic [31:0] mem      [16];
    logic [31:0] init_word[16];
    logic [31:0] ref_mem  [16];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          n_rd;
        int          n_wr;
        int          wr_cyc;
        logic [31:0] wr_data;
        logic [31:0] wr_addr;
        logic [31:0] rd_addr;
        int          n_both;
        int          n_busy_ready;
        logic        ready_at_start;
        longint      t_drive;
        longint      t_rsp;
    } obs_t;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          n_rd;
        int          n_wr;
        logic [31:0] wr_data;
        logic [31:0] waddr;
    } exp_t;

    mem_access_ctrl_if #(.ADDR_W(32)) bus_if ();

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .address    (address),
        .write_data (write_data),
        .memwrite   (memwrite),
        .memread    (memread),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: synchronous write, registered read (data valid the cycle after memread).
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word[i];
        end else if (memwrite) begin
            mem[address[3:0]] <= write_data;
        end
        if (memread) read_data <= mem[address[3:0]];
    end

    // Reference model: outcome of one request computed from byte arithmetic.
    task automatic model_req(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        int unsigned nb;
        int unsigned shift;
        int unsigned ri;
        logic [63:0] lmask;
        logic [63:0] v;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        e.err = (nb == 0) || ((a % nb) != 0);
`ifndef MEM_SUBWORD_EN
        if (nb != 4) e.err = 1'b1;
`endif
        e.waddr   = a / 4;
        e.rdata   = '0;
        e.wr_data = '0;
        e.n_rd    = 0;
        e.n_wr    = 0;
        ri        = (a / 4) % 16;
        if (e.err) begin
            e.lat = 1;
        end else begin
            shift = 8 * (a % 4);
            lmask = (64'd1 << (8 * nb)) - 1;
            if (!w) begin
                e.lat  = 3;
                e.n_rd = 1;
                v = ({32'd0, ref_mem[ri]} >> shift) & lmask;
                if (sg && v >= (lmask + 1) / 2) v = v - (lmask + 1);
                e.rdata = v[31:0];
            end else begin
                e.n_wr = 1;
                e.lat  = (nb == 4) ? 2 : 4;
                e.n_rd = (nb == 4) ? 0 : 1;
                v = ({32'd0, ref_mem[ri]} & ~(lmask << shift)) |
                    (({32'd0, wd} & lmask) << shift);
                e.wr_data   = v[31:0];
                ref_mem[ri] = v[31:0];
            end
        end
    endtask

    // Drive one request and record what the DUT does until its response.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, output obs_t o);
        o.lat = 0; o.err = 1'b0; o.rdata = '0; o.n_rd = 0; o.n_wr = 0; o.wr_cyc = 0;
        o.wr_data = '0; o.wr_addr = '0; o.rd_addr = '0; o.n_both = 0;
        o.n_busy_ready = 0; o.t_rsp = 0;
        @(negedge clk);
        o.t_drive        = $time;
        o.ready_at_start = bus_if.req_ready;
        bus_if.req_valid  = 1'b1;
        bus_if.req_write  = w;
        bus_if.req_size   = sz;
        bus_if.req_signed = sg;
        bus_if.req_addr   = a;
        bus_if.req_wdata  = wd;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (memread && memwrite) o.n_both++;
            if (memread) begin o.n_rd++; o.rd_addr = address; end
            if (memwrite) begin
                o.n_wr++; o.wr_cyc = c; o.wr_data = write_data; o.wr_addr = address;
            end
            if (bus_if.req_ready) o.n_busy_ready++;
            if (bus_if.rsp_valid) begin
                o.lat = c; o.err = bus_if.rsp_err; o.rdata = bus_if.rsp_rdata;
                o.t_rsp = $time;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus_if.req_valid = 1'b0; bus_if.req_write = 1'b0; bus_if.req_size = 2'b10;
        bus_if.req_signed = 1'b0; bus_if.req_addr = '0; bus_if.req_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            init_word[i] = $urandom;
        end
        init_word[11] = 32'h1122_3344;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word[i];
        reset = 1'b1;
        mem_load = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_err, memread, memwrite} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/rsp_valid/rsp_err/memread/memwrite got %b exp 10000",
                     {bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_err, memread, memwrite});
        end
        checks++;
        if (bus_if.rsp_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_rdata: got %h exp 00000000", bus_if.rsp_rdata);
        end
        checks++;
        if (write_data !== 32'd0) begin
            errors++; $display("FAIL reset_wdata: got %h exp 00000000", write_data);
        end
        checks++;
        if (address !== 32'd0) begin
            errors++; $display("FAIL reset_address: got %h exp 00000000", address);
        end
        reset = 1'b0;
        mem_load = 1'b0;
    endtask

    task automatic test_directed();
        logic        t_w   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0]  t_sz  [8] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
        logic        t_sg  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] t_a   [8] = '{32'h28, 32'h28, 32'h2D, 32'h2D, 32'h2D, 32'h2F, 32'h2A, 32'h2C};
        logic [31:0] t_wd  [8] = '{32'h1100, 32'h0, 32'hAB, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
`ifdef MEM_SUBWORD_EN
        logic        x_err [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int          x_lat [8] = '{2, 3, 4, 3, 3, 1, 1, 3};
        logic [31:0] x_rd  [8] = '{32'h0, 32'h1100, 32'h0, 32'hFFFF_FFAB, 32'hAB, 32'h0, 32'h0, 32'h44};
        logic [31:0] x_wr  [8] = '{32'h1100, 32'h0, 32'h1122_AB44, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
`else
        logic        x_err [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int          x_lat [8] = '{2, 3, 1, 1, 1, 1, 1, 1};
        logic [31:0] x_rd  [8] = '{32'h0, 32'h1100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] x_wr  [8] = '{32'h1100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
`endif
        exp_t e;
        obs_t o;
        int   n_rd;
        int   n_wr;
        for (int i = 0; i < 8; i++) begin
            model_req(t_w[i], t_sz[i], t_sg[i], t_a[i], t_wd[i], e);
            do_req(t_w[i], t_sz[i], t_sg[i], t_a[i], t_wd[i], o);
            n_wr = (!x_err[i] && t_w[i]) ? 1 : 0;
            n_rd = (!x_err[i] && !(t_w[i] && t_sz[i] == 2'd2)) ? 1 : 0;
            checks++;
            if (o.lat !== x_lat[i] || o.err !== x_err[i]) begin
                errors++;
                $display("FAIL dir[%0d] lat/err: got %0d/%b exp %0d/%b", i, o.lat, o.err, x_lat[i], x_err[i]);
            end
            checks++;
            if (o.rdata !== x_rd[i]) begin
                errors++; $display("FAIL dir[%0d] rdata: got %h exp %h", i, o.rdata, x_rd[i]);
            end
            checks++;
            if (o.n_rd !== n_rd || o.n_wr !== n_wr) begin
                errors++;
                $display("FAIL dir[%0d] strobes rd/wr: got %0d/%0d exp %0d/%0d", i, o.n_rd, o.n_wr, n_rd, n_wr);
            end
            if (n_wr == 1) begin
                checks++;
                if (o.wr_data !== x_wr[i] || o.wr_addr !== (t_a[i] >> 2) || o.wr_cyc !== x_lat[i] - 1) begin
                    errors++;
                    $display("FAIL dir[%0d] write data/addr/cycle: got %h/%h/%0d exp %h/%h/%0d", i,
                             o.wr_data, o.wr_addr, o.wr_cyc, x_wr[i], t_a[i] >> 2, x_lat[i] - 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        obs_t o;
        int   viol;
        // Reset on the edge that ends WRITE: memory still takes the write.
        model_req(1'b1, 2'd2, 1'b0, 32'h34, 32'hCAFE_F00D, e);
        @(negedge clk);
        bus_if.req_valid = 1'b1; bus_if.req_write = 1'b1; bus_if.req_size = 2'd2;
        bus_if.req_signed = 1'b0; bus_if.req_addr = 32'h34; bus_if.req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        checks++;
        if (memwrite !== 1'b1) begin
            errors++; $display("FAIL rst_write strobe: got %b exp 1", memwrite);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_if.rsp_valid, memwrite, memread, bus_if.req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rst_write after: rsp_valid/memwrite/memread/ready got %b exp 0001",
                     {bus_if.rsp_valid, memwrite, memread, bus_if.req_ready});
        end
        reset = 1'b0;
        viol = 0;
        repeat (4) begin
            @(negedge clk);
            if (memwrite || memread || bus_if.rsp_valid) viol++;
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL rst_write quiet: got %0d stray cycles exp 0", viol);
        end
        model_req(1'b0, 2'd2, 1'b0, 32'h34, 32'h0, e);
        do_req(1'b0, 2'd2, 1'b0, 32'h34, 32'h0, o);
        checks++;
        if (o.rdata !== e.rdata || o.lat !== e.lat) begin
            errors++;
            $display("FAIL rst_write readback: got %h lat %0d exp %h lat %0d", o.rdata, o.lat, e.rdata, e.lat);
        end

        // Reset during WAIT: request abandoned, memory untouched.
        @(negedge clk);
        bus_if.req_valid = 1'b1;
`ifdef MEM_SUBWORD_EN
        bus_if.req_write = 1'b1; bus_if.req_size = 2'd0; bus_if.req_addr = 32'h35;
`else
        bus_if.req_write = 1'b0; bus_if.req_size = 2'd2; bus_if.req_addr = 32'h34;
`endif
        bus_if.req_signed = 1'b0; bus_if.req_wdata = 32'h0000_005A;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        checks++;
        if (memread !== 1'b1) begin
            errors++; $display("FAIL rst_wait memread: got %b exp 1", memread);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_if.rsp_valid, memwrite, memread, bus_if.req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rst_wait after: rsp_valid/memwrite/memread/ready got %b exp 0001",
                     {bus_if.rsp_valid, memwrite, memread, bus_if.req_ready});
        end
        checks++;
        if ({bus_if.rsp_rdata, address, write_data} !== 96'd0) begin
            errors++;
            $display("FAIL rst_wait clear: rdata/address/wdata got %h/%h/%h exp 0/0/0",
                     bus_if.rsp_rdata, address, write_data);
        end
        reset = 1'b0;
        viol = 0;
        repeat (4) begin
            @(negedge clk);
            if (memwrite || memread || bus_if.rsp_valid) viol++;
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL rst_wait quiet: got %0d stray cycles exp 0", viol);
        end
        model_req(1'b0, 2'd2, 1'b0, 32'h34, 32'h0, e);
        do_req(1'b0, 2'd2, 1'b0, 32'h34, 32'h0, o);
        checks++;
        if (o.rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL rst_wait readback: got %h exp cafef00d", o.rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic        b_w  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  b_sz [6] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2};
        logic [31:0] b_a  [6] = '{32'h10, 32'h10, 32'h13, 32'h12, 32'h11, 32'h10};
        logic [31:0] b_wd [6] = '{32'h8765_4321, 32'h0, 32'h0, 32'h0000_BEEF, 32'h0, 32'h0};
        exp_t   e;
        obs_t   o;
        longint t0;
        int     sum_lat;
        sum_lat = 0;
        for (int i = 0; i < 6; i++) begin
            model_req(b_w[i], b_sz[i], 1'b1, b_a[i], b_wd[i], e);
            do_req(b_w[i], b_sz[i], 1'b1, b_a[i], b_wd[i], o);
            if (i == 0) t0 = o.t_drive;
            sum_lat += e.lat;
            checks++;
            if (o.ready_at_start !== 1'b1) begin
                errors++; $display("FAIL b2b[%0d] ready at issue: got %b exp 1", i, o.ready_at_start);
            end
            checks++;
            if (o.rdata !== e.rdata || o.err !== e.err || o.lat !== e.lat) begin
                errors++;
                $display("FAIL b2b[%0d] rsp: got %h/%b/%0d exp %h/%b/%0d", i,
                         o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
            end
        end
        checks++;
        if ((o.t_rsp - t0) / 10 !== longint'(sum_lat + 5)) begin
            errors++;
            $display("FAIL b2b total cycles: got %0d exp %0d", (o.t_rsp - t0) / 10, sum_lat + 5);
        end
    endtask

    task automatic test_random();
        exp_t        e;
        obs_t        o;
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        for (int n = 0; n < 80; n++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            wd = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz == 2'd2) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            model_req(w, sz, sg, a, wd, e);
            do_req(w, sz, sg, a, wd, o);
            checks++;
            if (o.lat !== e.lat || o.err !== e.err) begin
                errors++;
                $display("FAIL rand[%0d] lat/err: got %0d/%b exp %0d/%b (w=%b sz=%0d a=%h)",
                         n, o.lat, o.err, e.lat, e.err, w, sz, a);
            end
            checks++;
            if (o.rdata !== e.rdata) begin
                errors++; $display("FAIL rand[%0d] rdata: got %h exp %h", n, o.rdata, e.rdata);
            end
            checks++;
            if (o.n_rd !== e.n_rd || o.n_wr !== e.n_wr || o.n_both !== 0) begin
                errors++;
                $display("FAIL rand[%0d] strobes rd/wr/both: got %0d/%0d/%0d exp %0d/%0d/0",
                         n, o.n_rd, o.n_wr, o.n_both, e.n_rd, e.n_wr);
            end
            checks++;
            if (o.n_busy_ready !== 0 || o.ready_at_start !== 1'b1) begin
                errors++;
                $display("FAIL rand[%0d] req_ready: busy-high %0d start %b exp 0/1", n, o.n_busy_ready, o.ready_at_start);
            end
            if (e.n_rd == 1) begin
                checks++;
                if (o.rd_addr !== e.waddr) begin
                    errors++; $display("FAIL rand[%0d] read address: got %h exp %h", n, o.rd_addr, e.waddr);
                end
            end
            if (e.n_wr == 1) begin
                checks++;
                if (o.wr_data !== e.wr_data || o.wr_addr !== e.waddr || o.wr_cyc !== e.lat - 1) begin
                    errors++;
                    $display("FAIL rand[%0d] write data/addr/cycle: got %h/%h/%0d exp %h/%h/%0d", n,
                             o.wr_data, o.wr_addr, o.wr_cyc, e.wr_data, e.waddr, e.lat - 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
